// File: rtl/minigame_host.sv
// rtl/minigame_host.sv - minigame supervisor: button debounce, seed timebase,
// session FSM with timeout abort, result registers and 4-digit display scan.
module minigame_host #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TIMEOUT_SEC  = 60,
  parameter int SCAN_CYC     = 50_000
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       start_btn,
  input  logic       game_done,
  input  logic [3:0] game_score,
  output logic       game_enable,
  output logic       game_rst,
  output logic [3:0] seed,
  output logic       busy,
  output logic       timeout_flag,
  output logic [7:0] wins,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int CW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW = $clog2(SCAN_CYC + 1);
  localparam logic [3:0] TO_TENS = 4'(TIMEOUT_SEC / 10);
  localparam logic [3:0] TO_ONES = 4'(TIMEOUT_SEC % 10);

  typedef enum logic [2:0] {H_IDLE, H_ARM, H_RUN, H_FIN, H_ABORT} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cyc_cnt;
  logic          sec_tick;
  logic          sync1, sync2, db_level, start_evt;
  logic [DW-1:0] db_cnt;
  logic          arm_cnt, run_started;
  logic [3:0]    run_tens, run_ones, last_tens, last_ones, peak;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    digit_val;
  logic [7:0]    seg_nx;

  assign sec_tick = (cyc_cnt == CW'(CLK_HZ - 1));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      cyc_cnt <= '0;
      seed    <= '0;
    end else if (sec_tick) begin
      cyc_cnt <= '0;
      seed    <= (seed == 4'd9) ? 4'd0 : seed + 4'd1;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Level flips only after DEBOUNCE_CYC consecutive samples disagree with it.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_level  <= 1'b0;
      db_cnt    <= '0;
      start_evt <= 1'b0;
    end else begin
      sync1     <= start_btn;
      sync2     <= sync1;
      start_evt <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        db_cnt    <= '0;
        db_level  <= sync2;
        start_evt <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state <= H_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    game_enable = 1'b0;
    game_rst    = 1'b0;
    busy        = (state != H_IDLE);
    case (state)
      H_IDLE:  if (start_evt) state_nx = H_ARM;
      H_ARM: begin
        game_enable = 1'b1;
        if (arm_cnt) state_nx = H_RUN;
      end
      H_RUN: begin
        if (game_done)
          state_nx = H_FIN;
        else if (run_tens == TO_TENS && run_ones == TO_ONES && !sec_tick)
          state_nx = H_ABORT;
      end
      H_FIN:   state_nx = H_IDLE;
      H_ABORT: begin
        game_rst = 1'b1;
        state_nx = H_IDLE;
      end
      default: state_nx = H_IDLE;
    endcase
  end

  // The first tick inside H_RUN only starts the clock, so a partial
  // leading second is not counted.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      arm_cnt      <= 1'b0;
      run_started  <= 1'b0;
      run_tens     <= '0;
      run_ones     <= '0;
      last_tens    <= '0;
      last_ones    <= '0;
      peak         <= '0;
      wins         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        H_IDLE: if (start_evt) begin
          arm_cnt      <= 1'b0;
          run_started  <= 1'b0;
          run_tens     <= '0;
          run_ones     <= '0;
          peak         <= '0;
          timeout_flag <= 1'b0;
        end
        H_ARM: arm_cnt <= 1'b1;
        H_RUN: begin
          if (game_score > peak) peak <= game_score;
          if (sec_tick) begin
            if (!run_started) begin
              run_started <= 1'b1;
            end else if (!(run_tens == 4'd9 && run_ones == 4'd9)) begin
              if (run_ones == 4'd9) begin
                run_ones <= 4'd0;
                run_tens <= run_tens + 4'd1;
              end else begin
                run_ones <= run_ones + 4'd1;
              end
            end
          end
        end
        H_FIN: begin
          if (wins != 8'hFF) wins <= wins + 8'd1;
          last_tens <= run_tens;
          last_ones <= run_ones;
        end
        H_ABORT: begin
          timeout_flag <= 1'b1;
          last_tens    <= run_tens;
          last_ones    <= run_ones;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    digit_val = 4'hF;
    case (digit_idx)
      2'd0:    digit_val = busy ? run_ones : last_ones;
      2'd1:    digit_val = busy ? run_tens : last_tens;
      2'd3:    digit_val = peak;
      default: digit_val = 4'hF;
    endcase
    case (digit_val)
      4'd0:    seg_nx = 8'hC0;
      4'd1:    seg_nx = 8'hF9;
      4'd2:    seg_nx = 8'hA4;
      4'd3:    seg_nx = 8'hB0;
      4'd4:    seg_nx = 8'h99;
      4'd5:    seg_nx = 8'h92;
      4'd6:    seg_nx = 8'h82;
      4'd7:    seg_nx = 8'hF8;
      4'd8:    seg_nx = 8'h80;
      4'd9:    seg_nx = 8'h90;
      default: seg_nx = 8'hFF;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      seg       <= 8'hFF;
      an        <= 4'b1110;
    end else begin
      if (scan_cnt == SW'(SCAN_CYC - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg <= seg_nx;
      an  <= ~(4'b0001 << digit_idx);
    end
  end

endmodule
